reed_conditioner: RTL and testbench
===================================

// Module: reed_conditioner
// PURPOSE
//  Conditions the raw wheel reed-switch input for the trip-computer datapath: 2-FF synchroniser,
//  debounce filter, rising-edge one-shot with minimum-period lockout. Sits directly upstream of
//  the distance accumulator: reed_pulse drives its reed input, exactly 1 cycle per wheel turn.
//  Also measures wheel period in clock cycles (for speed) and flags a stopped wheel.
// PARAMETERS
//  DEBOUNCE_CYCLES  5     consecutive differing synchronised samples needed to change filtered level
//  LOCKOUT_CYCLES   60    cycles after an accepted pulse during which new rising edges are ignored
//  STOP_CYCLES      4000  cycles without an accepted pulse before stopped asserts
//  PERIOD_W         13    width of period counter/output; must satisfy 2^PERIOD_W-1 >= STOP_CYCLES
// PORTS
//  clock        in   1         system clock (1 kHz tick, defaults sized for it)
//  reset        in   1         synchronous, active-high reset
//  reed_raw     in   1         raw reed switch, asynchronous, bouncy, high = magnet present
//  reed_pulse   out  1         1-cycle pulse per accepted wheel revolution
//  period       out  PERIOD_W  cycles between last two accepted pulses (held)
//  period_valid out  1         1-cycle strobe, same cycle as reed_pulse, when period is updated
//  stopped      out  1         high while no accepted pulse for >= STOP_CYCLES cycles
// BEHAVIOUR
//  Reset (wins over all events): sync FFs=0, filtered=0, debounce cnt=0, lockout=0, period cnt=0,
//   reed_pulse=0, period=0, period_valid=0, stopped=1.
//  Sync: s1<=reed_raw, s2<=s1. Only s2 is used downstream.
//  Debounce: if s2==filtered -> cnt<=0; else if cnt==DEBOUNCE_CYCLES-1 -> filtered<=s2, cnt<=0;
//   else cnt<=cnt+1. Any matching sample restarts the count (glitch < DEBOUNCE_CYCLES rejected).
//  Edge: rise = filtered & ~filtered_d (filtered_d registered copy). Falling edges unused.
//  Accept = rise & (lockout==0). On accept: reed_pulse<=1 next cycle, lockout<=LOCKOUT_CYCLES-1.
//   Else lockout decrements to 0 and holds. Rise while lockout!=0: dropped, no pulse, no update.
//  Latency: reed_raw stable high from sampling edge N -> reed_pulse high for the cycle following
//   edge N+DEBOUNCE_CYCLES+3; exactly one cycle wide.
//  Period counter pc: on accept pc<=1; else pc<=pc+1 saturating at 2^PERIOD_W-1.
//   On accept with stopped==0: period<=pc (value before clear), period_valid<=1 with reed_pulse.
//   On accept with stopped==1: period unchanged, period_valid stays 0 (no reference edge).
//  Stopped: set when pc reaches STOP_CYCLES (no accept that cycle); cleared on accept.
//   Accept in the same cycle pc reaches STOP_CYCLES: accept wins, stopped stays 0, period valid.
//  Reset mid-debounce/mid-lockout: all state discarded; first post-reset pulse never strobes period.
//  Reed held high indefinitely: one pulse only; re-arm requires filtered low then high again.
// STRUCTURE
//  Shared include (trip-computer defines header): clock-rate constant and the default values of
//   DEBOUNCE_CYCLES, LOCKOUT_CYCLES, STOP_CYCLES, PERIOD_W, so distance/speed blocks agree.
//  One sub-module: reed_debounce (sync + debounce, ports clock, reset, in_raw, level, parameter
//   DEBOUNCE_CYCLES). Edge/lockout/period/stopped logic lives in reed_conditioner top.
// TESTING
//  1. Reset, reed_raw=1 steady from edge 10 -> single reed_pulse after edge 18 (DEBOUNCE=5),
//     period_valid=0, stopped still 1 then 0 after pulse.
//  2. Bounce: 3-cycle high, 1 low, 3 high, 1 low, then steady high -> exactly one reed_pulse,
//     timed from start of the steady-high run.
//  3. Clean pulses every 500 cycles (20 high) -> second and later pulses give period=500,
//     period_valid coincident with reed_pulse, stopped=0 throughout.
//  4. Two clean rises 40 cycles apart (< LOCKOUT 60) -> second ignored; next rise at 520 after
//     first -> period=520.
//  5. No pulse for 4000 cycles after an accept -> stopped=1 exactly when pc reaches 4000; next
//     accept clears stopped, period_valid=0, period holds previous value.
//  6. Assert reset 2 cycles mid-lockout and mid-debounce -> all outputs to reset values; next
//     clean rise produces pulse with no lockout suppression and period_valid=0.

Source files
------------

// File: rtl/reed_conditioner_pkg.sv
// Shared trip-computer constants: clock rate and the default timing of the
// wheel reed-switch conditioner, so the distance and speed blocks agree.
package reed_conditioner_pkg;

    // System tick rate in Hz; the cycle-count defaults below are sized for it.
    localparam int CLOCK_HZ = 1000;

    // Default debounce length, lockout after a revolution, and stopped timeout (4 s).
    localparam int DEF_DEBOUNCE_CYCLES = 5;
    localparam int DEF_LOCKOUT_CYCLES  = 60;
    localparam int DEF_STOP_CYCLES     = 4 * CLOCK_HZ;

    // Period counter width; 2^13-1 = 8191 comfortably covers the stop timeout.
    localparam int DEF_PERIOD_W        = 13;

    // Bits needed for a down/up counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/reed_debounce.sv
// Two-flop synchroniser followed by a run-length debounce filter for the raw
// reed switch. The filtered level only changes after DEBOUNCE_CYCLES
// consecutive synchronised samples disagree with it.
module reed_debounce
    import reed_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic in_raw,
    output logic level
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: shift the synchroniser, count disagreeing samples, and flip
    // the filtered level once the disagreement has lasted long enough.
    always_comb begin
        s1_d    = in_raw;
        s2_d    = s1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = s2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset forces the filter back to "magnet absent".
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/reed_conditioner.sv
// Wheel reed-switch conditioner: debounced level -> rising-edge one-shot with
// a minimum-period lockout, plus wheel period measurement and stopped flag.
// reed_pulse feeds the distance accumulator, one cycle per wheel turn.
module reed_conditioner
    import reed_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
    parameter int STOP_CYCLES     = DEF_STOP_CYCLES,
    parameter int PERIOD_W        = DEF_PERIOD_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                reed_raw,
    output logic                reed_pulse,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                stopped
);

    localparam int                  LOCK_W    = cnt_width(LOCKOUT_CYCLES - 1);
    localparam logic [LOCK_W-1:0]   LOCK_INIT = LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] PC_MAX    = '1;
    localparam logic [PERIOD_W-1:0] PC_ONE    = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] STOP_VAL  = PERIOD_W'(STOP_CYCLES);

    logic                level;
    logic                level_q, level_d;
    logic                level_prev_q, level_prev_d;
    logic [LOCK_W-1:0]   lockout_q, lockout_d;
    logic [PERIOD_W-1:0] pc_q, pc_d;
    logic [PERIOD_W-1:0] pc_inc;
    logic                reed_pulse_q, reed_pulse_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                period_valid_q, period_valid_d;
    logic                stopped_q, stopped_d;
    logic                rise;
    logic                accept;

    reed_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock  (clock),
        .reset  (reset),
        .in_raw (reed_raw),
        .level  (level)
    );

    // Next-state: retime the filtered level, detect accepted rising edges,
    // run the lockout and period counters, and update the measured period.
    // The extra level_q stage keeps edge detection on a local register rather
    // than directly on the sub-module output.
    always_comb begin
        level_d      = level;
        level_prev_d = level_q;
        rise         = level_q & ~level_prev_q;
        accept       = rise & (lockout_q == '0);

        lockout_d = lockout_q;
        if (accept) begin
            lockout_d = LOCK_INIT;
        end else if (lockout_q != '0) begin
            lockout_d = lockout_q - 1'b1;
        end

        pc_inc = (pc_q == PC_MAX) ? pc_q : pc_q + 1'b1;
        pc_d   = accept ? PC_ONE : pc_inc;

        stopped_d = stopped_q;
        if (accept) begin
            stopped_d = 1'b0;
        end else if (pc_inc >= STOP_VAL) begin
            stopped_d = 1'b1;
        end

        reed_pulse_d   = accept;
        period_valid_d = accept & ~stopped_q;
        period_d       = period_valid_d ? pc_q : period_q;
    end

    // State registers; reset discards any pending edge, lockout or period and
    // reports the wheel as stopped until a fresh reference pulse arrives.
    always_ff @(posedge clock) begin
        if (reset) begin
            level_q        <= 1'b0;
            level_prev_q   <= 1'b0;
            lockout_q      <= '0;
            pc_q           <= '0;
            reed_pulse_q   <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            stopped_q      <= 1'b1;
        end else begin
            level_q        <= level_d;
            level_prev_q   <= level_prev_d;
            lockout_q      <= lockout_d;
            pc_q           <= pc_d;
            reed_pulse_q   <= reed_pulse_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            stopped_q      <= stopped_d;
        end
    end

    assign reed_pulse   = reed_pulse_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign stopped      = stopped_q;

endmodule

// File: tb/tb_reed_conditioner.sv
// Directed, table-driven bench for reed_conditioner. Each table row drives
// reed_raw at a fixed level for a number of cycles and states how many pulses
// and period strobes must appear in that window, at which offset the pulse
// lands, and the period/stopped values at the end of the window.
module tb_reed_conditioner;

    localparam int PERIOD_W = 13;
    localparam int NSEG     = 22;

    typedef struct {
        logic raw;
        int   len;
        int   pulses;
        int   valids;
        int   ofs;
        int   period;
        logic stopped;
    } seg_t;

    logic                clock;
    logic                reset;
    logic                reed_raw;
    logic                reed_pulse;
    logic [PERIOD_W-1:0] period;
    logic                period_valid;
    logic                stopped;

    int   checks;
    int   errors;
    int   seg_pulses;
    int   seg_valids;
    int   seg_ofs;
    int   orphan_valids;
    seg_t segs [NSEG];

    reed_conditioner #(
        .DEBOUNCE_CYCLES (5),
        .LOCKOUT_CYCLES  (60),
        .STOP_CYCLES     (4000),
        .PERIOD_W        (PERIOD_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .reed_raw     (reed_raw),
        .reed_pulse   (reed_pulse),
        .period       (period),
        .period_valid (period_valid),
        .stopped      (stopped)
    );

    // 10 ns clock, first rising edge at 5 ns.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Hold reed_raw at one level for len cycles (driven and sampled on the
    // falling edge) and tally pulses, strobes and the last pulse offset.
    task automatic applyStimulus(input logic raw, input int len);
        reed_raw   = raw;
        seg_pulses = 0;
        seg_valids = 0;
        seg_ofs    = -1;
        for (int i = 1; i <= len; i++) begin
            @(negedge clock);
            if (reed_pulse === 1'b1) begin
                seg_pulses++;
                seg_ofs = i;
            end
            if (period_valid === 1'b1) begin
                seg_valids++;
                if (reed_pulse !== 1'b1) orphan_valids++;
            end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        orphan_valids = 0;

        // raw, len, pulses, valids, pulse offset, period, stopped
        segs[0]  = '{1'b1,   30, 1, 0,  9,   0, 1'b0}; // first pulse after reset
        segs[1]  = '{1'b0,  100, 0, 0, -1,   0, 1'b0};
        segs[2]  = '{1'b1,    3, 0, 0, -1,   0, 1'b0}; // bounce
        segs[3]  = '{1'b0,    1, 0, 0, -1,   0, 1'b0};
        segs[4]  = '{1'b1,    3, 0, 0, -1,   0, 1'b0};
        segs[5]  = '{1'b0,    1, 0, 0, -1,   0, 1'b0};
        segs[6]  = '{1'b1,   40, 1, 1,  9, 138, 1'b0}; // steady after bounce
        segs[7]  = '{1'b0,  100, 0, 0, -1, 138, 1'b0};
        segs[8]  = '{1'b1,   20, 1, 1,  9, 140, 1'b0}; // 500-cycle train
        segs[9]  = '{1'b0,  480, 0, 0, -1, 140, 1'b0};
        segs[10] = '{1'b1,   20, 1, 1,  9, 500, 1'b0};
        segs[11] = '{1'b0,  480, 0, 0, -1, 500, 1'b0};
        segs[12] = '{1'b1,   20, 1, 1,  9, 500, 1'b0};
        segs[13] = '{1'b0,  480, 0, 0, -1, 500, 1'b0};
        segs[14] = '{1'b1,   10, 1, 1,  9, 500, 1'b0}; // lockout: first rise
        segs[15] = '{1'b0,   30, 0, 0, -1, 500, 1'b0};
        segs[16] = '{1'b1,   10, 0, 0, -1, 500, 1'b0}; // rise 40 later dropped
        segs[17] = '{1'b0,  470, 0, 0, -1, 500, 1'b0};
        segs[18] = '{1'b1,   20, 1, 1,  9, 520, 1'b0}; // rise 520 after first
        segs[19] = '{1'b0, 3987, 0, 0, -1, 520, 1'b0}; // pc at 3999
        segs[20] = '{1'b0,    1, 0, 0, -1, 520, 1'b1}; // pc reaches 4000
        segs[21] = '{1'b1,   20, 1, 0,  9, 520, 1'b0}; // restart after stop

        reset    = 1'b1;
        reed_raw = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset reed_pulse",   int'(reed_pulse),   0);
        checkOutput("reset period",       int'(period),       0);
        checkOutput("reset period_valid", int'(period_valid), 0);
        checkOutput("reset stopped",      int'(stopped),      1);
        reset = 1'b0;

        for (int i = 0; i < NSEG; i++) begin
            applyStimulus(segs[i].raw, segs[i].len);
            checkOutput($sformatf("seg%0d pulses", i),  seg_pulses,      segs[i].pulses);
            checkOutput($sformatf("seg%0d valids", i),  seg_valids,      segs[i].valids);
            checkOutput($sformatf("seg%0d offset", i),  seg_ofs,         segs[i].ofs);
            checkOutput($sformatf("seg%0d period", i),  int'(period),    segs[i].period);
            checkOutput($sformatf("seg%0d stopped", i), int'(stopped),   int'(segs[i].stopped));
        end

        // Reset for two cycles while lockout is active and the filter is
        // part-way through debouncing a falling level.
        applyStimulus(1'b0, 3);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("midreset reed_pulse",   int'(reed_pulse),   0);
        checkOutput("midreset period",       int'(period),       0);
        checkOutput("midreset period_valid", int'(period_valid), 0);
        checkOutput("midreset stopped",      int'(stopped),      1);
        reset = 1'b0;

        applyStimulus(1'b0, 5);
        checkOutput("post-reset low pulses", seg_pulses, 0);
        applyStimulus(1'b1, 20);
        checkOutput("post-reset pulses",  seg_pulses,    1);
        checkOutput("post-reset offset",  seg_ofs,       9);
        checkOutput("post-reset valids",  seg_valids,    0);
        checkOutput("post-reset period",  int'(period),  0);
        checkOutput("post-reset stopped", int'(stopped), 0);

        checkOutput("strobe without pulse", orphan_valids, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
